// File: rtl/axi_frame_pkg.sv
// Shared definitions for the frame transmit / frame-fetch stream pair.
//   frame_state_e : transmit FSM states (idle, streaming pixel groups, draining the skid buffer)
//   DEFAULT_*     : default frame size and AXI-Stream widths used by both ends of the stream
package axi_frame_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDrain
   } frame_state_e;

   // 320x240 pixels, 32 pixels of 8 bits per group
   localparam int unsigned DEFAULT_FRAME_PGNUM = 2400;
   localparam int unsigned DEFAULT_TID_W       = 2;
   localparam int unsigned DEFAULT_TDATA_W     = 256;

endpackage

// File: rtl/axi_frame_stream_if.sv
// AXI4-Stream bundle between the frame transmitter and the frame-fetch path.
//   master : drives tid, tdest, tdata, tkeep, tstrb, tlast, tvalid; samples tready
//   slave  : samples the payload and tvalid; drives tready
interface axi_frame_stream_if
   import axi_frame_pkg::*;
#(
   parameter int unsigned TID_W   = DEFAULT_TID_W,
   parameter int unsigned TDEST_W = 1,
   parameter int unsigned TDATA_W = DEFAULT_TDATA_W
);

   localparam int unsigned TKEEP_W = TDATA_W / 8;

   logic [TID_W-1:0]   tid;
   logic [TDEST_W-1:0] tdest;
   logic [TDATA_W-1:0] tdata;
   logic [TKEEP_W-1:0] tkeep;
   logic [TKEEP_W-1:0] tstrb;
   logic               tlast;
   logic               tvalid;
   logic               tready;

   modport master (
      output tid, tdest, tdata, tkeep, tstrb, tlast, tvalid,
      input  tready
   );

   modport slave (
      input  tid, tdest, tdata, tkeep, tstrb, tlast, tvalid,
      output tready
   );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with a registered output stage.
//   clk, rst    : clock, synchronous active-high reset
//   in_data_i   : payload to push; in_valid_i / in_ready_o handshake
//   out_data_o  : head entry; out_valid_o / out_ready_i handshake
// in_ready_o and out_valid_o depend on the occupancy register only, so neither
// side sees a combinational path from the other side's handshake.
module axis_skid_buffer
   import axi_frame_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   assign in_ready_o  = (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = head_q;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      unique case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = in_data_i;
            end else begin
               tail_d = in_data_i;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         // Simultaneous push and pop only happens with one entry held.
         2'b11: head_d = in_data_i;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/axi_frame_stream.sv
// Packs one frame of pixel groups into one AXI4-Stream packet per frame_start_i,
// rotating tdest across IP_AMT image processors frame by frame.
//   clk, rst          : clock, synchronous active-high reset
//   frame_start_i     : pulse arming one frame (ignored unless idle)
//   pgroup_i/_valid_i : pixel-group input; pgroup_ready_o accepts
//   m_axis            : AXI4-Stream master (tlast on the final pixel group)
//   busy_o            : high while not idle
//   frame_done_o      : pulse the cycle after the tlast handshake
module axi_frame_stream
   import axi_frame_pkg::*;
#(
   parameter int unsigned IP_AMT       = 1,
   parameter int unsigned AXIS_TDEST_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1,
   parameter int unsigned AXIS_TID_W   = DEFAULT_TID_W,
   parameter int unsigned AXIS_TID_VAL = 0,
   parameter int unsigned AXIS_TDATA_W = DEFAULT_TDATA_W,
   parameter int unsigned AXIS_TKEEP_W = AXIS_TDATA_W / 8,
   parameter int unsigned AXIS_TSTRB_W = AXIS_TDATA_W / 8,
   parameter int unsigned FRAME_PGNUM  = DEFAULT_FRAME_PGNUM,
   parameter int unsigned PGCNT_W      = (FRAME_PGNUM > 1) ? $clog2(FRAME_PGNUM) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start_i,
   input  logic [AXIS_TDATA_W-1:0] pgroup_i,
   input  logic                    pgroup_valid_i,
   output logic                    pgroup_ready_o,
   axi_frame_stream_if.master      m_axis,
   output logic                    busy_o,
   output logic                    frame_done_o
);

   // Skid entry layout: {data, dest, last}
   localparam int unsigned PAYLOAD_W = AXIS_TDATA_W + AXIS_TDEST_W + 1;

   frame_state_e            state_q, state_d;
   logic [PGCNT_W-1:0]      pg_cnt_q, pg_cnt_d;
   logic [AXIS_TDEST_W-1:0] dest_ptr_q, dest_ptr_d;
   logic [AXIS_TDEST_W-1:0] cur_dest_q, cur_dest_d;
   logic                    done_q, done_d;

   logic                    skid_in_ready, accept, last_pg, last_hs;
   logic                    out_valid, out_last;
   logic [PAYLOAD_W-1:0]    out_payload;
   logic [AXIS_TDATA_W-1:0] out_data;
   logic [AXIS_TDEST_W-1:0] out_dest;

   assign last_pg        = (pg_cnt_q == PGCNT_W'(FRAME_PGNUM - 1));
   assign pgroup_ready_o = (state_q == StStream) && skid_in_ready;
   assign accept         = pgroup_valid_i && pgroup_ready_o;
   assign {out_data, out_dest, out_last} = out_payload;
   assign last_hs        = out_valid && m_axis.tready && out_last;

   axis_skid_buffer #(
      .WIDTH (PAYLOAD_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   ({pgroup_i, cur_dest_q, last_pg}),
      .in_valid_i  (accept),
      .in_ready_o  (skid_in_ready),
      .out_data_o  (out_payload),
      .out_valid_o (out_valid),
      .out_ready_i (m_axis.tready)
   );

   assign m_axis.tid    = AXIS_TID_W'(AXIS_TID_VAL);
   assign m_axis.tdest  = out_dest;
   assign m_axis.tdata  = out_data;
   assign m_axis.tkeep  = {AXIS_TKEEP_W{1'b1}};
   assign m_axis.tstrb  = {AXIS_TSTRB_W{1'b1}};
   assign m_axis.tlast  = out_last;
   assign m_axis.tvalid = out_valid;

   assign busy_o       = (state_q != StIdle);
   assign frame_done_o = done_q;

   always_comb begin
      state_d    = state_q;
      pg_cnt_d   = pg_cnt_q;
      dest_ptr_d = dest_ptr_q;
      cur_dest_d = cur_dest_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (frame_start_i) begin
               state_d    = StStream;
               pg_cnt_d   = '0;
               cur_dest_d = dest_ptr_q;
            end
         end
         StStream: begin
            if (accept) begin
               // Counter holds at FRAME_PGNUM-1 on the final accept.
               if (last_pg) begin
                  state_d = StDrain;
               end else begin
                  pg_cnt_d = pg_cnt_q + PGCNT_W'(1);
               end
            end
         end
         StDrain: begin
            if (last_hs) begin
               state_d    = StIdle;
               done_d     = 1'b1;
               dest_ptr_d = (dest_ptr_q == AXIS_TDEST_W'(IP_AMT - 1)) ?
                            '0 : dest_ptr_q + AXIS_TDEST_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pg_cnt_q   <= '0;
         dest_ptr_q <= '0;
         cur_dest_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pg_cnt_q   <= pg_cnt_d;
         dest_ptr_q <= dest_ptr_d;
         cur_dest_q <= cur_dest_d;
         done_q     <= done_d;
      end
   end

endmodule
